// File: rtl/bwram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one byte-write RAM port.
// Responses come back RD_LAT cycles after acceptance, routed via a valid+id pipeline.
module bwram_port_arbiter #(
    parameter int AW     = 10,
    parameter int NB     = 4,
    parameter int DW     = NB * 8,  // must equal NB*8
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_valid,
    output logic          m0_ready,
    input  logic [NB-1:0] m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_valid,
    output logic          m1_ready,
    input  logic [NB-1:0] m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic [NB-1:0] ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,

    output logic [15:0]   gnt_cnt0,
    output logic [15:0]   gnt_cnt1
);

    // ptr_q == 0 favours m0 under contention, 1 favours m1
    logic              ptr_q, ptr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     din_q, din_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] id_q, id_d;
    logic [15:0]       cnt0_q, cnt0_d;
    logic [15:0]       cnt1_q, cnt1_d;

    logic              acc;
    logic              gnt_id;
    logic [NB-1:0]     sel_we;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_din;

    always_comb begin
        m0_ready = rst_n && m0_valid && (!m1_valid || !ptr_q);
        m1_ready = rst_n && m1_valid && (!m0_valid || ptr_q);
        acc      = m0_ready || m1_ready;
        gnt_id   = m1_ready;
        sel_we   = gnt_id ? m1_we    : m0_we;
        sel_addr = gnt_id ? m1_addr  : m0_addr;
        sel_din  = gnt_id ? m1_wdata : m0_wdata;
    end

    // Address/data shadow keeps the RAM port stable while idle
    always_comb begin
        ram_we   = acc ? sel_we   : '0;
        ram_addr = acc ? sel_addr : addr_q;
        ram_din  = acc ? sel_din  : din_q;
        addr_d   = acc ? sel_addr : addr_q;
        din_d    = acc ? sel_din  : din_q;
        ptr_d    = acc ? !gnt_id  : ptr_q;
    end

    always_comb begin
        vld_d    = '0;
        id_d     = '0;
        vld_d[0] = acc;
        id_d[0]  = gnt_id;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (m0_ready && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
        if (m1_ready && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            vld_q  <= '0;
            id_q   <= '0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            vld_q  <= vld_d;
            id_q   <= id_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    // RAM data is valid exactly when the last pipeline stage is, so rdata passes straight through
    always_comb begin
        m0_rvalid = vld_q[RD_LAT-1] && !id_q[RD_LAT-1];
        m1_rvalid = vld_q[RD_LAT-1] &&  id_q[RD_LAT-1];
        m0_rdata  = m0_rvalid ? ram_dout : '0;
        m1_rdata  = m1_rvalid ? ram_dout : '0;
        gnt_cnt0  = cnt0_q;
        gnt_cnt1  = cnt1_q;
    end

endmodule

// File: tb/tb_bwram_port_arbiter.sv
// Directed bench for bwram_port_arbiter with an input-registered, write-first byte-write RAM model.
module tb_bwram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_valid, m1_valid;
    logic        m0_ready, m1_ready;
    logic [3:0]  m0_we, m1_we;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic [15:0] gnt_cnt0, gnt_cnt1;

    int errors = 0;
    int checks = 0;

    bwram_port_arbiter #(.AW(10), .NB(4), .DW(32), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: inputs registered on one edge, write/read-out on the next (2-cycle latency)
    logic [31:0] mem [0:1023];
    logic [3:0]  r_we;
    logic [9:0]  r_addr;
    logic [31:0] r_din;
    logic [31:0] dout_q;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] din);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++)
            if (we[b]) w[b*8 +: 8] = din[b*8 +: 8];
        return w;
    endfunction

    always @(posedge clk) begin
        r_we         <= ram_we;
        r_addr       <= ram_addr;
        r_din        <= ram_din;
        mem[r_addr]  <= merge(mem[r_addr], r_we, r_din);
        dout_q       <= merge(mem[r_addr], r_we, r_din);
    end
    assign ram_dout = dout_q;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated transaction; returns what was observed, caller compares.
    task automatic issue(input bit m, input logic [3:0] we, input logic [9:0] addr,
                         input logic [31:0] wd, output logic rdy, output logic rv,
                         output logic [31:0] rd, output logic stray);
        @(negedge clk);
        if (m) begin m1_valid = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd; end
        else   begin m0_valid = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd; end
        #1 rdy = m ? m1_ready : m0_ready;
        @(negedge clk);
        m0_valid = 1'b0; m1_valid = 1'b0;
        #1 stray = m0_rvalid | m1_rvalid;
        @(negedge clk);
        #1;
        rv    = m ? m1_rvalid : m0_rvalid;
        rd    = m ? m1_rdata  : m0_rdata;
        stray = stray | (m ? m0_rvalid : m1_rvalid);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_valid = 1'b1; m1_valid = 1'b1;
        m0_we = 4'hF; m1_we = 4'h3; m0_addr = 10'h12; m1_addr = 10'h34;
        m0_wdata = 32'h11111111; m1_wdata = 32'h22222222;
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({m0_ready, m1_ready} !== 2'b00)
            $display("FAIL reset_ready got=%b exp=00", {m0_ready, m1_ready});
        checks++; if (ram_we !== 4'h0) begin errors++; $display("FAIL reset_ram_we got=%h exp=0", ram_we); end
        checks++; if (ram_addr !== 10'h0 || ram_din !== 32'h0) begin
            errors++; $display("FAIL reset_ram_addr_din got=%h/%h exp=0/0", ram_addr, ram_din); end
        checks++; if (gnt_cnt0 !== 16'h0 || gnt_cnt1 !== 16'h0) begin
            errors++; $display("FAIL reset_cnt got=%h/%h exp=0/0", gnt_cnt0, gnt_cnt1); end
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_resp got=%b %h %h exp=00 0 0", {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata); end
        if ({m0_ready, m1_ready} !== 2'b00) errors++;
        @(negedge clk);
        m0_valid = 1'b0; m1_valid = 1'b0; m0_we = 4'h0; m1_we = 4'h0;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic rdy, rv, stray;
        logic [31:0] rd;
        logic [1:0] exp_rdy, exp_rv;
        logic [31:0] exp_data, got_data;
        issue(1'b0, 4'hF, 10'd5, 32'h05050505, rdy, rv, rd, stray);
        checks++; if (rdy !== 1'b1 || rv !== 1'b1 || rd !== 32'h05050505 || stray !== 1'b0) begin
            errors++; $display("FAIL wr_addr5 got=%b%b%b %h exp=110 05050505", rdy, rv, stray, rd); end
        issue(1'b1, 4'hF, 10'd9, 32'h09090909, rdy, rv, rd, stray);
        checks++; if (rdy !== 1'b1 || rv !== 1'b1 || rd !== 32'h09090909 || stray !== 1'b0) begin
            errors++; $display("FAIL wr_addr9 got=%b%b%b %h exp=110 09090909", rdy, rv, stray, rd); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            m0_valid = (c < 6); m1_valid = (c < 6);
            m0_we = 4'h0; m1_we = 4'h0; m0_addr = 10'd5; m1_addr = 10'd9;
            #1;
            if (c < 6) begin
                exp_rdy = (c % 2 == 1) ? 2'b01 : 2'b10;
                checks++; if ({m0_ready, m1_ready} !== exp_rdy) begin
                    errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, {m0_ready, m1_ready}, exp_rdy); end
                checks++; if (ram_addr !== ((c % 2 == 1) ? 10'd9 : 10'd5)) begin
                    errors++; $display("FAIL rr_ram_addr c=%0d got=%0d", c, ram_addr); end
            end
            if (c >= 2) begin
                exp_rv   = ((c - 2) % 2 == 1) ? 2'b01 : 2'b10;
                exp_data = ((c - 2) % 2 == 1) ? 32'h09090909 : 32'h05050505;
                got_data = ((c - 2) % 2 == 1) ? m1_rdata : m0_rdata;
                checks++; if ({m0_rvalid, m1_rvalid} !== exp_rv || got_data !== exp_data) begin
                    errors++; $display("FAIL rr_resp c=%0d got=%b %h exp=%b %h", c,
                                       {m0_rvalid, m1_rvalid}, got_data, exp_rv, exp_data); end
            end else begin
                checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
                    errors++; $display("FAIL rr_early_resp c=%0d got=%b exp=00", c, {m0_rvalid, m1_rvalid}); end
            end
        end
    endtask

    task automatic test_write();
        logic rdy, rv, stray;
        logic [31:0] rd;
        issue(1'b0, 4'b1111, 10'd3, 32'hAABBCCDD, rdy, rv, rd, stray);
        checks++; if (rdy !== 1'b1 || rv !== 1'b1 || rd !== 32'hAABBCCDD || stray !== 1'b0) begin
            errors++; $display("FAIL wr_full got=%b%b%b %h exp=110 aabbccdd", rdy, rv, stray, rd); end
        issue(1'b1, 4'b0010, 10'd3, 32'h00001100, rdy, rv, rd, stray);
        checks++; if (rdy !== 1'b1 || rv !== 1'b1 || rd !== 32'hAABB11DD || stray !== 1'b0) begin
            errors++; $display("FAIL wr_partial got=%b%b%b %h exp=110 aabb11dd", rdy, rv, stray, rd); end
        issue(1'b0, 4'b0000, 10'd3, 32'hFFFFFFFF, rdy, rv, rd, stray);
        checks++; if (rdy !== 1'b1 || rv !== 1'b1 || rd !== 32'hAABB11DD || stray !== 1'b0) begin
            errors++; $display("FAIL rd_after_wr got=%b%b%b %h exp=110 aabb11dd", rdy, rv, stray, rd); end
    endtask

    task automatic test_only_m1();
        int pulses1, pulses0;
        pulses1 = 0; pulses0 = 0;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            m0_valid = 1'b0; m1_valid = (c < 4); m1_we = 4'h0; m1_addr = 10'd9;
            #1;
            if (c < 4) begin
                checks++; if ({m0_ready, m1_ready} !== 2'b01) begin
                    errors++; $display("FAIL m1_only_ready c=%0d got=%b exp=01", c, {m0_ready, m1_ready}); end
            end
            if (m1_rvalid) begin
                pulses1++;
                checks++; if (m1_rdata !== 32'h09090909 || c < 2 || c > 5) begin
                    errors++; $display("FAIL m1_only_rdata c=%0d got=%h exp=09090909 in c=2..5", c, m1_rdata); end
            end
            if (m0_rvalid) pulses0++;
        end
        checks++; if (pulses1 != 4 || pulses0 != 0) begin
            errors++; $display("FAIL m1_only_pulses got=%0d/%0d exp=4/0", pulses1, pulses0); end
        checks++; if (gnt_cnt1 !== 16'd4 || gnt_cnt0 !== 16'd0) begin
            errors++; $display("FAIL m1_only_cnt got=%0d/%0d exp=4/0", gnt_cnt1, gnt_cnt0); end
    endtask

    task automatic test_reset_inflight();
        int late;
        late = 0;
        @(negedge clk);
        m0_valid = 1'b1; m0_we = 4'h0; m0_addr = 10'd5;
        #1;
        checks++; if (m0_ready !== 1'b1) begin
            errors++; $display("FAIL rst_inflight_accept got=%b exp=1", m0_ready); end
        @(negedge clk);
        m0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin
            errors++; $display("FAIL rst_async_cnt got=%0d/%0d exp=0/0", gnt_cnt0, gnt_cnt1); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (m0_rvalid || m1_rvalid) late++;
        end
        checks++; if (late != 0) begin
            errors++; $display("FAIL rst_dropped_resp got=%0d pulses exp=0", late); end
        @(negedge clk);
        m0_valid = 1'b1; m1_valid = 1'b1; m0_we = 4'h0; m1_we = 4'h0;
        #1;
        checks++; if ({m0_ready, m1_ready} !== 2'b10) begin
            errors++; $display("FAIL rst_first_grant got=%b exp=10", {m0_ready, m1_ready}); end
        @(negedge clk);
        m0_valid = 1'b0; m1_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_idle();
        @(negedge clk);
        m0_valid = 1'b1; m0_we = 4'hF; m0_addr = 10'd7; m0_wdata = 32'h12345678;
        #1;
        checks++; if (ram_we !== 4'hF || ram_addr !== 10'd7 || ram_din !== 32'h12345678) begin
            errors++; $display("FAIL idle_grant0 got=%h %0d %h exp=f 7 12345678", ram_we, ram_addr, ram_din); end
        @(negedge clk);
        m0_valid = 1'b0; m0_addr = 10'h3FF; m0_wdata = 32'hFFFFFFFF;
        #1;
        checks++; if (ram_we !== 4'h0 || ram_addr !== 10'd7 || ram_din !== 32'h12345678) begin
            errors++; $display("FAIL idle_hold0 got=%h %0d %h exp=0 7 12345678", ram_we, ram_addr, ram_din); end
        @(negedge clk);
        m1_valid = 1'b1; m1_we = 4'h0; m1_addr = 10'd9; m1_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (ram_we !== 4'h0 || ram_addr !== 10'd9 || ram_din !== 32'hDEADBEEF) begin
            errors++; $display("FAIL idle_grant1 got=%h %0d %h exp=0 9 deadbeef", ram_we, ram_addr, ram_din); end
        @(negedge clk);
        m1_valid = 1'b0; m1_addr = 10'd1; m1_wdata = 32'h0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (ram_we !== 4'h0 || ram_addr !== 10'd9 || ram_din !== 32'hDEADBEEF) begin
                errors++; $display("FAIL idle_hold1 c=%0d got=%h %0d %h exp=0 9 deadbeef", c, ram_we, ram_addr, ram_din); end
            @(negedge clk);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        @(negedge clk);
        m0_valid = 1'b1; m0_we = 4'h0; m0_addr = 10'd5;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        m0_valid = 1'b0;
        #1;
        checks++; if (gnt_cnt0 !== 16'hFFFE) begin
            errors++; $display("FAIL sat_pre got=%h exp=fffe", gnt_cnt0); end
        @(negedge clk);
        m0_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        m0_valid = 1'b0;
        #1;
        checks++; if (gnt_cnt0 !== 16'hFFFF || gnt_cnt1 !== 16'h0) begin
            errors++; $display("FAIL sat_stick got=%h/%h exp=ffff/0", gnt_cnt0, gnt_cnt1); end
        @(negedge clk);
        m0_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m0_valid = 1'b0;
        #1;
        checks++; if (gnt_cnt0 !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold got=%h exp=ffff", gnt_cnt0); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_we = 4'h0; m1_we = 4'h0; m0_addr = '0; m1_addr = '0;
        m0_wdata = '0; m1_wdata = '0;
        test_reset();
        test_round_robin();
        test_write();
        test_only_m1();
        test_reset_inflight();
        test_idle();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
